// File: rtl/genius_pkg.sv
// genius_pkg: shared definitions for the Genius game player-side logic.
//   COLOR_W / ADDR_W : widths of the one-hot colour bus and the sequence ROM address
//   state_t          : checker FSM states
//   FAIL_*           : fail_code values reported to the game controller
//   more_than_one    : true when a button vector has two or more bits set
package genius_pkg;

  localparam int COLOR_W = 4;
  localparam int ADDR_W  = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ARM          = 2'd1,
    WAIT_PRESS   = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_WRONG   = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b10;
  localparam logic [1:0] FAIL_MULTI   = 2'b11;

  // Clearing the lowest set bit leaves something only if another bit was set.
  function automatic logic more_than_one(input logic [COLOR_W-1:0] b);
    return (b & (b - COLOR_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/seq_check_if.sv
// seq_check_if: handshake between the player buttons, the sequence ROM and the game
// controller on one side (master) and the sequence checker (slave) on the other.
//   start, round_len   : round request from the controller
//   buttons            : debounced one-hot-ish player buttons
//   seq_addr/seq_color : sequence ROM address out, expected colour back (combinational)
//   busy, step_ok, round_pass, round_fail, fail_code : checker status
interface seq_check_if;
  import genius_pkg::*;

  logic               start;
  logic [ADDR_W-1:0]  round_len;
  logic [COLOR_W-1:0] buttons;
  logic [ADDR_W-1:0]  seq_addr;
  logic [COLOR_W-1:0] seq_color;
  logic               busy;
  logic               step_ok;
  logic               round_pass;
  logic               round_fail;
  logic [1:0]         fail_code;

  modport master (
    output start, round_len, buttons, seq_color,
    input  seq_addr, busy, step_ok, round_pass, round_fail, fail_code
  );

  modport slave (
    input  start, round_len, buttons, seq_color,
    output seq_addr, busy, step_ok, round_pass, round_fail, fail_code
  );

endinterface

// File: rtl/seq_check_timer.sv
// step_timer: per-step idle counter for the sequence checker.
//   clk, rst  : clock, asynchronous active-high reset
//   i_clr     : synchronous clear (wins over i_en)
//   i_en      : count one cycle
//   o_expired : count has reached TIMEOUT_CYCLES-1
module step_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_count;

  // Idle-cycle counter; the checker leaves the counting states once expired,
  // so the count never needs to saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TMR_W'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/seq_check.sv
// seq_check: walks the colour sequence ROM and compares each player press with
// the expected colour, reporting per-step success, round pass or round fail.
//   clk, rst : clock, asynchronous active-high reset
//   io_seq   : slave side of seq_check_if (start/round_len/buttons/seq_color in,
//              seq_addr/busy/step_ok/round_pass/round_fail/fail_code out)
module seq_check
  import genius_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input logic        clk,
  input logic        rst,
  seq_check_if.slave io_seq
);

  state_t             r_state;
  logic [COLOR_W-1:0] r_btn_q;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_len;
  logic               r_busy;
  logic               r_step_ok;
  logic               r_pass;
  logic               r_fail;
  logic [1:0]         r_code;

  logic w_btn_idle;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expired;

  assign w_btn_idle = (r_btn_q == '0);
  // Clear on round start; also held clear while waiting for release, so the
  // next step starts counting from zero.
  assign w_tmr_clr  = ((r_state == IDLE) && io_seq.start) || (r_state == WAIT_RELEASE);
  // Only cycles with no button down count towards the step timeout.
  assign w_tmr_en   = ((r_state == ARM) || (r_state == WAIT_PRESS)) && w_btn_idle;

  step_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_step_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  // Single register stage on the buttons; the FSM only ever looks at r_btn_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_q <= '0;
    end else begin
      r_btn_q <= io_seq.buttons;
    end
  end

  // Checker FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_busy    <= 1'b0;
      r_step_ok <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_code    <= FAIL_NONE;
    end else begin
      r_step_ok <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_seq.start) begin
            r_addr  <= '0;
            r_code  <= FAIL_NONE;
            r_len   <= io_seq.round_len;
            r_busy  <= 1'b1;
            r_state <= ARM;
          end
        end
        ARM: begin
          // A button held over from before the round must be released first.
          if (w_btn_idle) begin
            r_state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (w_btn_idle) begin
            if (w_expired) begin
              r_fail  <= 1'b1;
              r_code  <= FAIL_TIMEOUT;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else if (more_than_one(r_btn_q)) begin
            r_fail  <= 1'b1;
            r_code  <= FAIL_MULTI;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_btn_q == io_seq.seq_color) begin
            r_step_ok <= 1'b1;
            r_state   <= WAIT_RELEASE;
          end else begin
            r_fail  <= 1'b1;
            r_code  <= FAIL_WRONG;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (w_btn_idle) begin
            if (r_addr == r_len) begin
              r_pass  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= WAIT_PRESS;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_seq.seq_addr   = r_addr;
  assign io_seq.busy       = r_busy;
  assign io_seq.step_ok    = r_step_ok;
  assign io_seq.round_pass = r_pass;
  assign io_seq.round_fail = r_fail;
  assign io_seq.fail_code  = r_code;

endmodule
